microwave: RTL and testbench



---
 rtl/microwave_pkg.sv | 71 +++++++
 rtl/bcd_to_7seg.sv | 25 ++
 rtl/microwave.sv | 153 +++++++++++++++
 tb/tb_microwave.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types, glyph constants and BCD time helpers for the microwave controller.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] tens;
    logic [3:0] ones;
  } cook_time_t;

  // Active-high segments, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Lowest set key wins when several keys are down together.
  function automatic logic [3:0] key_digit(logic [9:0] keys);
    logic [3:0] d;
    d = '0;
    for (int i = 9; i >= 0; i--) begin
      if (keys[i]) d = 4'(i);
    end
    return d;
  endfunction

  // Entered seconds above 59 roll into the minutes digit, saturating at 9:59.
  function automatic cook_time_t normalize(cook_time_t t);
    cook_time_t r;
    r = t;
    if (t.tens > 4'd5) begin
      if (t.min == 4'd9) begin
        r = '{min: 4'd9, tens: 4'd5, ones: 4'd9};
      end else begin
        r.min  = t.min + 4'd1;
        r.tens = t.tens - 4'd6;
      end
    end
    return r;
  endfunction

  function automatic cook_time_t bcd_dec(cook_time_t t);
    cook_time_t r;
    r = t;
    if (t.ones != 4'd0) begin
      r.ones = t.ones - 4'd1;
    end else begin
      r.ones = 4'd9;
      if (t.tens != 4'd0) begin
        r.tens = t.tens - 4'd1;
      end else begin
        r.tens = 4'd5;
        r.min  = t.min - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to an active-high 7-segment glyph; codes 10-15 are blanked.
module bcd_to_7seg
  import microwave_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segs
);

  always_comb begin
    case (bcd)
      4'd0:    segs = SEG_0;
      4'd1:    segs = SEG_1;
      4'd2:    segs = SEG_2;
      4'd3:    segs = SEG_3;
      4'd4:    segs = SEG_4;
      4'd5:    segs = SEG_5;
      4'd6:    segs = SEG_6;
      4'd7:    segs = SEG_7;
      4'd8:    segs = SEG_8;
      4'd9:    segs = SEG_9;
      default: segs = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/microwave.sv
// Microwave-oven controller: keypad entry, M:SS countdown, magnetron enable.
// Build option: define MICROWAVE_DEBOUNCE_EN to filter keypad bounces.
module microwave
  import microwave_pkg::*;
#(
  parameter int CLK_HZ = 100
`ifdef MICROWAVE_DEBOUNCE_EN
  , parameter int DEB_CYCLES = 4
`endif
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic [9:0] keypad,
  output logic [6:0] sec_ones_segs,
  output logic [6:0] sec_tens_segs,
  output logic [6:0] min_segs,
  output logic       mag_on
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  // Idle levels: no keys, start/stop released, door treated as open.
  localparam logic [12:0] SYNC_RST = {10'b0, 1'b1, 1'b1, 1'b0};

  logic [12:0] sync_1;
  logic [12:0] sync_2;
  logic [9:0]  key_s;
  logic        start_s;
  logic        stop_s;
  logic        door_s;

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      sync_1 <= SYNC_RST;
      sync_2 <= SYNC_RST;
    end else begin
      // NOTE: non-blocking so each flop of the chain samples the pre-edge value.
      sync_1 <= {keypad, startn, stopn, door_closed};
      sync_2 <= sync_1;
    end
  end

  assign key_s   = sync_2[12:3];
  assign start_s = sync_2[2];
  assign stop_s  = sync_2[1];
  assign door_s  = sync_2[0];

  logic       key_accept;
  logic [9:0] key_value;

`ifdef MICROWAVE_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [9:0]    key_last;
  logic [CW-1:0] stable_cnt;
  logic          armed;

  // stable_cnt = cycles key_last has held; a held press fires once, then re-arms on a stable release.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      key_last   <= '0;
      stable_cnt <= '0;
      armed      <= 1'b1;
    end else begin
      key_last <= key_s;
      if (key_s != key_last) begin
        stable_cnt <= CW'(1);
      end else if (stable_cnt != CW'(DEB_CYCLES)) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      if (stable_cnt == CW'(DEB_CYCLES)) begin
        armed <= (key_last == '0);
      end
    end
  end

  assign key_accept = armed && (key_last != '0) && (stable_cnt == CW'(DEB_CYCLES));
  assign key_value  = key_last;
`else
  logic [9:0] key_prev;

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) key_prev <= '0;
    else         key_prev <= key_s;
  end

  assign key_accept = (key_s != '0) && (key_prev == '0);
  assign key_value  = key_s;
`endif

  state_t        state, state_n;
  cook_time_t    cook_time, time_n;
  logic [PW-1:0] presc, presc_n;
  logic          start_ok;
  logic          stop_req;

  assign start_ok = !start_s && door_s && (cook_time != '0);
  assign stop_req = !stop_s || !door_s;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_n = state;
    time_n  = cook_time;
    presc_n = presc;
    case (state)
      IDLE: begin
        if (start_ok) begin
          time_n  = normalize(cook_time);
          presc_n = '0;
          state_n = COOK;
        end else if (key_accept) begin
          time_n = '{min: cook_time.tens, tens: cook_time.ones, ones: key_digit(key_value)};
        end
      end
      COOK: begin
        if (stop_req) begin
          state_n = PAUSE;
        end else if (presc == PW'(CLK_HZ - 1)) begin
          presc_n = '0;
          time_n  = bcd_dec(cook_time);
          if (time_n == '0) state_n = IDLE;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      PAUSE: begin
        if (start_ok && !stop_req) state_n = COOK;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state     <= IDLE;
      cook_time <= '0;
      presc     <= '0;
      mag_on    <= 1'b0;
    end else begin
      state     <= state_n;
      cook_time <= time_n;
      presc     <= presc_n;
      mag_on    <= (state_n == COOK);
    end
  end

  bcd_to_7seg u_ones (.bcd(cook_time.ones), .segs(sec_ones_segs));
  bcd_to_7seg u_tens (.bcd(cook_time.tens), .segs(sec_tens_segs));
  bcd_to_7seg u_min  (.bcd(cook_time.min),  .segs(min_segs));

endmodule

// File: tb/tb_microwave.sv
// Scoreboard bench for microwave: stimulus queues expected display/mag_on changes, a monitor checks each change.
module tb_microwave;

  localparam int CLK_HZ = 100;

  logic       clock;
  logic       clearn;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic [9:0] keypad;
  logic [6:0] sec_ones_segs;
  logic [6:0] sec_tens_segs;
  logic [6:0] min_segs;
  logic       mag_on;

  microwave dut (
    .clock        (clock),
    .clearn       (clearn),
    .startn       (startn),
    .stopn        (stopn),
    .door_closed  (door_closed),
    .keypad       (keypad),
    .sec_ones_segs(sec_ones_segs),
    .sec_tens_segs(sec_tens_segs),
    .min_segs     (min_segs),
    .mag_on       (mag_on)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int m;
    int t;
    int o;
    bit mag;
    int gap;  // required cycles since previous change, 0 = any
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          em, et, eo;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          last_cyc = 0;
  logic [21:0] prev_out;

  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [21:0] outs_now();
    return {min_segs, sec_tens_segs, sec_ones_segs, mag_on};
  endfunction

  // Monitor: every change of the visible outputs must match the next queued expectation.
  initial begin
    logic [21:0] cur;
    logic [21:0] want;
    exp_t        e;
    forever begin
      @(negedge clock);
      cyc++;
      if (mon_en) begin
        cur = outs_now();
        if (cur !== prev_out) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got %h at cycle %0d, nothing expected", cur, cyc);
          end else begin
            e    = sb.pop_front();
            want = {glyph(e.m), glyph(e.t), glyph(e.o), e.mag};
            if (cur !== want || (e.gap != 0 && (cyc - last_cyc) != e.gap)) begin
              errors++;
              $display("FAIL event %0d:%0d%0d mag=%0d: got outs=%h gap=%0d, want outs=%h gap=%0d",
                       e.m, e.t, e.o, e.mag, cur, cyc - last_cyc, want, e.gap);
            end
          end
          prev_out = cur;
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic expect_ev(input int m, input int t, input int o, input bit mag, input int gap);
    exp_t e;
    e = '{m: m, t: t, o: o, mag: mag, gap: gap};
    sb.push_back(e);
  endtask

  // Queues n countdown steps from (em,et,eo); the step reaching 0:00 drops mag_on.
  task automatic push_decs(input int n, input int first_gap);
    for (int i = 0; i < n; i++) begin
      if (eo != 0) begin
        eo--;
      end else begin
        eo = 9;
        if (et != 0) begin
          et--;
        end else begin
          et = 5;
          em--;
        end
      end
      expect_ev(em, et, eo, !(em == 0 && et == 0 && eo == 0), (i == 0) ? first_gap : CLK_HZ);
    end
  endtask

  task automatic press(input int d);
    keypad = 10'd1 << d;
    tick(10);
    keypad = '0;
    tick(10);
  endtask

  task automatic push_start();
    startn = 1'b0;
    tick(4);
    startn = 1'b1;
  endtask

  task automatic push_stop();
    stopn = 1'b0;
    tick(4);
    stopn = 1'b1;
  endtask

  task automatic pulse_clear();
    clearn = 1'b0;
    tick(2);
    clearn = 1'b1;
    tick(2);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d expected changes still pending after %0d cycles, want 0",
               name, sb.size(), budget);
      sb.delete();
    end
  endtask

  initial begin
    clearn      = 1'b0;
    startn      = 1'b1;
    stopn       = 1'b1;
    door_closed = 1'b1;
    keypad      = '0;
    tick(3);
    clearn = 1'b1;
    tick(1);

    checks++;
    if (outs_now() !== {7'h3F, 7'h3F, 7'h3F, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h, want %h", outs_now(), {7'h3F, 7'h3F, 7'h3F, 1'b0});
    end
    prev_out = outs_now();
    mon_en   = 1'b1;

    // Keys 4,4,7, cook, door opens and closes, run to 0:00.
    expect_ev(0, 0, 4, 0, 0);
    expect_ev(0, 4, 4, 0, 0);
    expect_ev(4, 4, 7, 0, 0);
    press(4); press(4); press(7);
    expect_ev(4, 4, 7, 1, 0);
    expect_ev(4, 4, 6, 1, CLK_HZ);
    expect_ev(4, 4, 6, 0, 0);
    push_start();
    tick(146);
    door_closed = 1'b0;
    tick(50);
    wait_drain("door_open", 10);
    door_closed = 1'b1;
    tick(2);
    expect_ev(4, 4, 6, 1, 0);
    em = 4; et = 4; eo = 6;
    push_decs(286, 0);
    push_start();
    wait_drain("countdown_447", 30000);

    // Door open: 3:92 entered, start ignored; closed start normalizes to 4:32.
    door_closed = 1'b0;
    tick(5);
    expect_ev(0, 0, 3, 0, 0);
    expect_ev(0, 3, 9, 0, 0);
    expect_ev(3, 9, 2, 0, 0);
    press(3); press(9); press(2);
    push_start();
    tick(20);
    wait_drain("door_open_start", 5);
    door_closed = 1'b1;
    tick(5);
    expect_ev(4, 3, 2, 1, 0);
    em = 4; et = 3; eo = 2;
    push_decs(30, CLK_HZ);
    expect_ev(4, 0, 2, 0, 0);
    push_start();
    tick(3001);
    push_stop();
    tick(50);
    wait_drain("stop_402", 10);
    expect_ev(4, 0, 2, 1, 0);
    push_decs(3, 0);
    push_start();
    wait_drain("resume_402", 500);
    expect_ev(0, 0, 0, 0, 0);
    pulse_clear();
    wait_drain("clear_after_resume", 20);

    // Keys 2,2,5 (bounce on the 5 in the debounce build), cook to 0:00.
    expect_ev(0, 0, 2, 0, 0);
    expect_ev(0, 2, 2, 0, 0);
    expect_ev(2, 2, 5, 0, 0);
    press(2); press(2);
`ifdef MICROWAVE_DEBOUNCE_EN
    keypad = 10'd1 << 5;
    tick(2);
    keypad = '0;
    tick(2);
`endif
    press(5);
    expect_ev(2, 2, 5, 1, 0);
    em = 2; et = 2; eo = 5;
    push_decs(145, CLK_HZ);
    push_start();
    wait_drain("countdown_225", 16000);

    // Held key enters once; two keys together: lowest index wins.
    expect_ev(0, 0, 1, 0, 0);
    press(1);
    expect_ev(0, 1, 5, 0, 0);
    keypad = 10'd1 << 5;
    tick(3000);
    keypad = '0;
    tick(10);
    expect_ev(1, 5, 6, 0, 0);
    keypad = (10'd1 << 6) | (10'd1 << 8);
    tick(10);
    keypad = '0;
    tick(10);
    wait_drain("held_key", 20);
    expect_ev(0, 0, 0, 0, 0);
    pulse_clear();
    wait_drain("clear_156", 20);

    // Clear while idle, then clear while cooking.
    expect_ev(0, 0, 2, 0, 0);
    expect_ev(0, 2, 5, 0, 0);
    expect_ev(2, 5, 0, 0, 0);
    press(2); press(5); press(0);
    expect_ev(0, 0, 0, 0, 0);
    pulse_clear();
    wait_drain("clear_idle", 20);
    expect_ev(0, 0, 1, 0, 0);
    expect_ev(0, 1, 5, 0, 0);
    expect_ev(1, 5, 0, 0, 0);
    press(1); press(5); press(0);
    expect_ev(1, 5, 0, 1, 0);
    push_start();
    wait_drain("start_150", 20);
    expect_ev(0, 0, 0, 0, 0);
    clearn = 1'b0;
    #1;
    checks++;
    if (mag_on !== 1'b0) begin
      errors++;
      $display("FAIL clear_mag_async: got mag_on=%b, want 0", mag_on);
    end
    tick(2);
    clearn = 1'b1;
    tick(2);
    wait_drain("clear_cook", 20);

    // Keys pressed while cooking are ignored.
    expect_ev(0, 0, 2, 0, 0);
    expect_ev(0, 2, 0, 0, 0);
    expect_ev(2, 0, 5, 0, 0);
    press(2); press(0); press(5);
    expect_ev(2, 0, 5, 1, 0);
    em = 2; et = 0; eo = 5;
    push_decs(2, CLK_HZ);
    push_start();
    press(3); press(5); press(0);
    wait_drain("cook_keys", 300);
    expect_ev(0, 0, 0, 0, 0);
    pulse_clear();
    wait_drain("final_clear", 20);
    tick(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
